// File: rtl/scan_capture_pkg.sv
// Shared types and constants for the scan-synchronous extrema capture block.
package scan_capture_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ACQ   = 2'd2
   } state_t;

   // Default widths: scan/signal resolution and counter width
   localparam int unsigned R_DEF  = 14;
   localparam int unsigned CW_DEF = 32;

   // Tracker modes
   localparam int unsigned MODE_MAX = 0;
   localparam int unsigned MODE_MIN = 1;

   // Tie-break: strict compare, so the first occurrence of an extreme wins
   localparam bit STRICT_COMPARE = 1'b1;

endpackage

// File: rtl/extremum_tracker.sv
// Running maximum or minimum of a signed value, with the position where it occurred.
module extremum_tracker
   import scan_capture_pkg::*;
#(
   parameter int unsigned R    = R_DEF,
   parameter int unsigned MODE = MODE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                init,
   input  logic                update,
   input  logic signed [R-1:0] value,
   input  logic signed [R-1:0] pos,
   output logic signed [R-1:0] best_val,
   output logic signed [R-1:0] best_pos
);

   logic better_c;

   // Does the incoming value beat the current best in this tracker's direction
   always_comb begin
      better_c = 1'b0;
      if (MODE == MODE_MAX) begin
         better_c = STRICT_COMPARE ? (value > best_val) : (value >= best_val);
      end else begin
         better_c = STRICT_COMPARE ? (value < best_val) : (value <= best_val);
      end
   end

   // Seed on init, otherwise replace only when the new sample is better
   always_ff @(posedge clk) begin
      if (rst) begin
         best_val <= '0;
         best_pos <= '0;
      end else if (init) begin
         best_val <= value;
         best_pos <= pos;
      end else if (update && better_c) begin
         best_val <= value;
         best_pos <= pos;
      end
   end

endmodule

// File: rtl/scan_extrema_capture.sv
// Per-half-sweep signal extrema capture, synchronised to the scan generator triggers.
module scan_extrema_capture
   import scan_capture_pkg::*;
#(
   parameter int unsigned R  = R_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 trigger_low,
   input  logic                 trigger_hig,
   input  logic signed [R-1:0]  scan_A,
   input  logic signed [R-1:0]  sig_in,
   output logic                 res_valid,
   output logic                 res_dir,
   output logic signed [R-1:0]  max_val,
   output logic signed [R-1:0]  min_val,
   output logic signed [R-1:0]  max_pos,
   output logic signed [R-1:0]  min_pos,
   output logic [CW-1:0]        n_samples,
   output logic [CW-1:0]        sweep_cnt,
   output logic                 busy
);

   state_t                state;
   logic                  run_dir;
   logic [CW-1:0]         run_cnt;
   logic                  trig_c;
   logic                  run_ok_c;
   logic                  trk_init_c;
   logic                  trk_update_c;
   logic                  trk_rst_c;
   logic signed [R-1:0]   run_max_val;
   logic signed [R-1:0]   run_max_pos;
   logic signed [R-1:0]   run_min_val;
   logic signed [R-1:0]   run_min_pos;

   // Tracker control: seed on any accepted trigger, accumulate on ACQ cycles without one
   always_comb begin
      trig_c       = trigger_low | trigger_hig;
      run_ok_c     = enable & ~clear;
      trk_init_c   = run_ok_c & trig_c & ((state == ARMED) | (state == ACQ));
      trk_update_c = run_ok_c & ~trig_c & (state == ACQ);
      trk_rst_c    = rst | clear;
   end

   extremum_tracker #(.R(R), .MODE(MODE_MAX)) u_max (
      .clk      (clk),
      .rst      (trk_rst_c),
      .init     (trk_init_c),
      .update   (trk_update_c),
      .value    (sig_in),
      .pos      (scan_A),
      .best_val (run_max_val),
      .best_pos (run_max_pos)
   );

   extremum_tracker #(.R(R), .MODE(MODE_MIN)) u_min (
      .clk      (clk),
      .rst      (trk_rst_c),
      .init     (trk_init_c),
      .update   (trk_update_c),
      .value    (sig_in),
      .pos      (scan_A),
      .best_val (run_min_val),
      .best_pos (run_min_pos)
   );

   // FSM, sample/sweep counters and publish registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         run_dir   <= 1'b0;
         run_cnt   <= '0;
         res_valid <= 1'b0;
         res_dir   <= 1'b0;
         max_val   <= '0;
         min_val   <= '0;
         max_pos   <= '0;
         min_pos   <= '0;
         n_samples <= '0;
         sweep_cnt <= '0;
         busy      <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (clear) begin
            state     <= enable ? ARMED : IDLE;
            run_dir   <= 1'b0;
            run_cnt   <= '0;
            sweep_cnt <= '0;
            busy      <= 1'b0;
         end else if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= ARMED;
                  busy  <= 1'b0;
               end
               ARMED: begin
                  if (trig_c) begin
                     state   <= ACQ;
                     busy    <= 1'b1;
                     run_dir <= trigger_low;
                     run_cnt <= CW'(1);
                  end
               end
               ACQ: begin
                  if (trig_c) begin
                     res_valid <= 1'b1;
                     res_dir   <= run_dir;
                     max_val   <= run_max_val;
                     max_pos   <= run_max_pos;
                     min_val   <= run_min_val;
                     min_pos   <= run_min_pos;
                     n_samples <= run_cnt;
                     sweep_cnt <= sweep_cnt + CW'(1);
                     run_dir   <= trigger_low;
                     run_cnt   <= CW'(1);
                  end else if (run_cnt != {CW{1'b1}}) begin
                     run_cnt <= run_cnt + CW'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_extrema_capture.sv
// Directed-vector bench for scan_extrema_capture with hand-computed expectations.
module tb_scan_extrema_capture;

   localparam int unsigned R  = 14;
   localparam int unsigned CW = 32;

   logic                clk;
   logic                rst;
   logic                enable;
   logic                clear;
   logic                trigger_low;
   logic                trigger_hig;
   logic signed [R-1:0] scan_A;
   logic signed [R-1:0] sig_in;
   logic                res_valid;
   logic                res_dir;
   logic signed [R-1:0] max_val;
   logic signed [R-1:0] min_val;
   logic signed [R-1:0] max_pos;
   logic signed [R-1:0] min_pos;
   logic [CW-1:0]       n_samples;
   logic [CW-1:0]       sweep_cnt;
   logic                busy;

   int n_vec;
   int n_err;
   int pulses;

   scan_extrema_capture #(.R(R), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .clear       (clear),
      .trigger_low (trigger_low),
      .trigger_hig (trigger_hig),
      .scan_A      (scan_A),
      .sig_in      (sig_in),
      .res_valid   (res_valid),
      .res_dir     (res_dir),
      .max_val     (max_val),
      .min_val     (min_val),
      .max_pos     (max_pos),
      .min_pos     (min_pos),
      .n_samples   (n_samples),
      .sweep_cnt   (sweep_cnt),
      .busy        (busy)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch
   task automatic check(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus; outputs are sampled 1 ns after the edge
   task automatic drive(input logic tl, input logic th, input int sc, input int sg);
      trigger_low = tl;
      trigger_hig = th;
      scan_A      = R'(sc);
      sig_in      = R'(sg);
      @(posedge clk);
      #1;
      if (res_valid) pulses++;
      trigger_low = 1'b0;
      trigger_hig = 1'b0;
   endtask

   // Check a full publication
   task automatic check_pub(input string tag, input int dir, input int mx, input int mxp,
                            input int mn, input int mnp, input int ns, input int sw);
      check({tag, ".valid"}, longint'(res_valid), 1);
      check({tag, ".dir"},   longint'(res_dir), longint'(dir));
      check({tag, ".max"},   longint'(max_val), longint'(mx));
      check({tag, ".maxpos"},longint'(max_pos), longint'(mxp));
      check({tag, ".min"},   longint'(min_val), longint'(mn));
      check({tag, ".minpos"},longint'(min_pos), longint'(mnp));
      check({tag, ".n"},     longint'(n_samples), longint'(ns));
      check({tag, ".sweep"}, longint'(sweep_cnt), longint'(sw));
   endtask

   int ramp_sig [10] = '{3, 7, 2, 7, -5, 1, 0, 4, 6, 2};

   initial begin
      n_vec = 0;
      n_err = 0;
      pulses = 0;
      rst = 1'b1;
      enable = 1'b0;
      clear = 1'b0;
      trigger_low = 1'b0;
      trigger_hig = 1'b0;
      scan_A = '0;
      sig_in = '0;

      // Reset state
      repeat (3) drive(1'b0, 1'b0, 0, 0);
      check("rst.valid", longint'(res_valid), 0);
      check("rst.dir",   longint'(res_dir), 0);
      check("rst.busy",  longint'(busy), 0);
      check("rst.max",   longint'(max_val), 0);
      check("rst.min",   longint'(min_val), 0);
      check("rst.maxpos",longint'(max_pos), 0);
      check("rst.minpos",longint'(min_pos), 0);
      check("rst.n",     longint'(n_samples), 0);
      check("rst.sweep", longint'(sweep_cnt), 0);

      // Enabled with no triggers: nothing happens
      rst = 1'b0;
      enable = 1'b1;
      pulses = 0;
      repeat (100) drive(1'b0, 1'b0, 5, 5);
      check("idle.pulses", longint'(pulses), 0);
      check("idle.busy",   longint'(busy), 0);
      check("idle.max",    longint'(max_val), 0);
      check("idle.sweep",  longint'(sweep_cnt), 0);

      // Rising half-sweep: scan 0..9, closed by trigger_hig
      pulses = 0;
      drive(1'b1, 1'b0, 0, ramp_sig[0]);
      check("arm.busy",  longint'(busy), 1);
      for (int i = 1; i < 10; i++) drive(1'b0, 1'b0, i, ramp_sig[i]);
      check("ramp.pulses", longint'(pulses), 0);
      drive(1'b0, 1'b1, 10, 9);
      check_pub("ramp", 1, 7, 1, -5, 4, 10, 1);
      drive(1'b0, 1'b0, 11, -2);
      check("ramp.strobe", longint'(res_valid), 0);
      check("ramp.hold",   longint'(max_val), 7);

      // Falling half-sweep seeded by (10,9); closed by both triggers at once
      drive(1'b0, 1'b0, 12, 12);
      drive(1'b1, 1'b1, 13, 0);
      check_pub("both", 0, 12, 12, -2, 11, 3, 2);
      drive(1'b0, 1'b0, 14, 5);
      drive(1'b0, 1'b1, 15, -3);
      check_pub("after_both", 1, 5, 14, 0, 13, 2, 3);

      // Clear together with a trigger: no publication, sweep count zeroed
      drive(1'b0, 1'b0, 16, 1);
      clear = 1'b1;
      drive(1'b0, 1'b1, 17, 100);
      clear = 1'b0;
      check("clr.valid", longint'(res_valid), 0);
      check("clr.sweep", longint'(sweep_cnt), 0);
      check("clr.busy",  longint'(busy), 0);
      check("clr.hold",  longint'(max_val), 5);
      check("clr.n",     longint'(n_samples), 2);
      drive(1'b1, 1'b0, 20, 4);
      check("clr.rearm_valid", longint'(res_valid), 0);
      check("clr.rearm_busy",  longint'(busy), 1);
      drive(1'b0, 1'b0, 21, 8);
      drive(1'b0, 1'b1, 22, -1);
      check_pub("post_clr", 1, 8, 21, 4, 20, 2, 1);

      // Enable dropped for one cycle mid-ACQ: sweep discarded, outputs held
      drive(1'b0, 1'b0, 23, 50);
      enable = 1'b0;
      pulses = 0;
      drive(1'b0, 1'b0, 24, 60);
      check("en.busy", longint'(busy), 0);
      enable = 1'b1;
      drive(1'b1, 1'b0, 25, 70);
      check("en.idle_trig_busy", longint'(busy), 0);
      check("en.pulses", longint'(pulses), 0);
      check("en.hold_max", longint'(max_val), 8);
      check("en.hold_sweep", longint'(sweep_cnt), 1);

      // Back-to-back triggers: arm, then two one-sample publications
      drive(1'b0, 1'b1, 30, 1);
      check("b2b.arm_valid", longint'(res_valid), 0);
      check("b2b.arm_busy",  longint'(busy), 1);
      drive(1'b1, 1'b0, 31, 2);
      check_pub("b2b1", 0, 1, 30, 1, 30, 1, 2);
      drive(1'b0, 1'b1, 32, 3);
      check_pub("b2b2", 1, 2, 31, 2, 31, 1, 3);
      drive(1'b0, 1'b0, 33, 3);
      check("b2b.strobe", longint'(res_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scan_extrema_capture.md
# scan_extrema_capture

Scan-synchronous capture block on the receive side of the scan generator. It consumes the scan generator's `trigger_low`/`trigger_hig` pulses and scan value, and watches a lock-in/error signal over each half-sweep. For each half-sweep it records the signal maximum and minimum together with the scan values at which they occurred, then publishes the results with a one-cycle valid strobe. The lock/relock logic and the register bank read these results to place the lock point.

## Interface
Parameters:
- `R`, 14, resolution of scan and signal inputs and of the value outputs.
- `CW`, 32, width of the sample and sweep counters.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  capture enable; low forces IDLE.
- `clear`  in  1  synchronous restart; discards the running half-sweep and re-arms.
- `trigger_low`  in  1  scan-at-low-limit pulse from the scan generator.
- `trigger_hig`  in  1  scan-at-high-limit pulse from the scan generator.
- `scan_A`  in  R signed  current scan value.
- `sig_in`  in  R signed  signal under observation.
- `res_valid`  out  1  one-cycle strobe: the result outputs were just updated.
- `res_dir`  out  1  direction of the published half-sweep: 1 = rising (started at `trigger_low`), 0 = falling.
- `max_val`, `min_val`  out  R signed  signal extremes of the published half-sweep.
- `max_pos`, `min_pos`  out  R signed  `scan_A` value at each extreme.
- `n_samples`  out  CW  samples in the published half-sweep (saturating).
- `sweep_cnt`  out  CW  number of published half-sweeps since reset or `clear` (wraps).
- `busy`  out  1  high in ACQ.

## Operation
- States: IDLE, ARMED, ACQ.
- IDLE: entered on `rst` or when `enable`=0; when `enable`=1, next state is ARMED. Results are held while in IDLE.
- ARMED: waits for the first trigger.
  - On a trigger: go to ACQ; `run_dir` = 1 if `trigger_low`, else 0.
  - The trigger-cycle sample initialises the trackers: max = min = `sig_in`, both positions = `scan_A`, count = 1.
  - Nothing is published.
- ACQ, each cycle without a trigger:
  - If `sig_in` > run_max, update run_max and max_pos. Strict compare, so the first occurrence wins ties.
  - If `sig_in` < run_min, update run_min and min_pos. Strict compare.
  - Increment the count, saturating at 2^CW−1.
- ACQ, trigger cycle:
  - Publish the running values, which exclude the trigger-cycle sample, to the outputs.
  - `res_dir` = run_dir; pulse `res_valid`; `sweep_cnt` +1.
  - Re-initialise the trackers from the trigger-cycle sample and set run_dir from the new trigger.
  - Stay in ACQ.
- Both triggers in the same cycle (low_lim = hig_lim): treat as `trigger_low`, so the new `run_dir` is 1.
- `clear`: running trackers reset; `sweep_cnt` := 0; state := ARMED if `enable`, else IDLE. Published results hold. `clear` has priority over a simultaneous trigger, and that trigger is ignored.
- `enable` falling mid-ACQ: the running half-sweep is discarded and nothing is published.
- Signed two's-complement compares throughout. No arithmetic on values.

## Timing
- Reset values:
  - `res_valid` = 0, `res_dir` = 0, `busy` = 0.
  - `max_val`, `min_val`, `max_pos`, `min_pos` = 0.
  - `n_samples` = 0, `sweep_cnt` = 0.
  - State = IDLE.
- Latency:
  - Trigger in cycle t → outputs updated at edge t+1, `res_valid` high during cycle t+1 only.
  - Outputs are stable until the next publication.
- Minimum half-sweep is 1 sample. Triggers in consecutive cycles each publish, with `n_samples` = 1.
- `busy` is registered: high from the cycle after the arming trigger until leaving ACQ.
- `rst` has priority over `clear`, which has priority over triggers.

## Structure
- Shared package `scan_capture_pkg` holds:
  - the state enum (IDLE, ARMED, ACQ);
  - the default widths `R` and `CW`;
  - the tie-break convention constant (strict compare).
- Sub-module `extremum_tracker`, instantiated twice (max and min) and selected by a `MODE` parameter.
  - Ports: `init`, `update`, `value`, `pos`; outputs `best_val`, `best_pos`.
- The top level holds the FSM, the counters and the publish registers.

## Test plan
- Reset then `enable`=1, no triggers for 100 cycles → `res_valid` never asserted, all outputs 0, `busy`=0.
- Triggers:
  - `trigger_low` at t0; ramp `scan_A` from 0 to 9 with `sig_in` = {3,7,2,7,−5,1,0,4,6,2};
  - `trigger_hig` at t0+10.
  - Required response in cycle t0+11:
    - `res_valid`=1 for one cycle, `res_dir`=1;
    - `max_val`=7, `max_pos`=1, `min_val`=−5, `min_pos`=4;
    - `n_samples`=10, `sweep_cnt`=1.
- Back-to-back triggers in cycles 50, 51, 52 → publications at 52 and 53, each with `n_samples`=1; `res_dir` follows the trigger that started each half-sweep.
- `trigger_low` and `trigger_hig` both high in the same cycle while in ACQ → one publication; the next published `res_dir`=1.
- `clear` mid-sweep, together with a `trigger_hig` → no publication, `sweep_cnt`=0, state ARMED; the next trigger arms without publishing.
- `enable` dropped for 1 cycle mid-ACQ → no publication and outputs held; re-arming needs a fresh trigger.
